// File: rtl/pifo_max_sched.sv
// rtl/pifo_max_sched.sv - register PIFO scheduler with iterative pairwise max search (PIFO_SCHED_MIN_EN selects min)
module pifo_max_sched #(
    parameter int REG_WIDTH  = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [RANK_WIDTH-1:0] ins_rank,
    input  logic [META_WIDTH-1:0] ins_meta,
    input  logic                  deq_req,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [RANK_WIDTH-1:0] deq_rank,
    output logic [META_WIDTH-1:0] deq_meta,
    output logic [IDX_WIDTH-1:0]  deq_idx,
    output logic [IDX_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full
);

    localparam int HALF = REG_WIDTH / 2;
    localparam logic [IDX_WIDTH:0]   FULL_CNT = (IDX_WIDTH+1)'(REG_WIDTH);
    localparam logic [IDX_WIDTH:0]   ONE_CNT  = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH-1:0] LAST_LVL = IDX_WIDTH'(IDX_WIDTH-1);
    localparam logic [IDX_WIDTH-1:0] ONE_LVL  = IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Slot array: only changed by an insert or a completed dequeue handshake
    logic [REG_WIDTH-1:0]  slot_valid;
    logic [RANK_WIDTH-1:0] slot_rank [REG_WIDTH];
    logic [META_WIDTH-1:0] slot_meta [REG_WIDTH];

    // Search registers; level k of the tree lives in the low entries
    logic [REG_WIDTH-1:0]  lvl_valid;
    logic [RANK_WIDTH-1:0] lvl_rank [REG_WIDTH];
    logic [IDX_WIDTH-1:0]  lvl_idx  [REG_WIDTH];
    logic [IDX_WIDTH-1:0]  lvl_cnt;

    logic [HALF-1:0]       left_better;
    logic [HALF-1:0]       take_left;
    logic [HALF-1:0]       red_valid;
    logic [RANK_WIDTH-1:0] red_rank [HALF];
    logic [IDX_WIDTH-1:0]  red_idx  [HALF];

    logic [IDX_WIDTH-1:0]  free_idx;
    logic                  do_insert;
    logic                  do_snap;
    logic                  do_deq;
    logic                  search_last;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign do_insert   = ins_valid && ins_ready;
    assign do_snap     = (state == IDLE) && !do_insert && deq_req && !empty;
    assign do_deq      = (state == PRESENT) && deq_ready;
    assign search_last = (state == SEARCH) && (lvl_cnt == LAST_LVL);

    // Lowest-index free slot; scanning downward lets the lowest free index win
    always_comb begin
        free_idx = '0;
        for (int i = REG_WIDTH - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = IDX_WIDTH'(i);
            end
        end
    end

    // One tree level: pair (2k, 2k+1) collapses into entry k, ties go to the right (higher index)
    always_comb begin
        left_better = '0;
        take_left   = '0;
        red_valid   = '0;
        for (int k = 0; k < HALF; k++) begin
`ifdef PIFO_SCHED_MIN_EN
            left_better[k] = lvl_rank[2*k] < lvl_rank[2*k+1];
`else
            left_better[k] = lvl_rank[2*k] > lvl_rank[2*k+1];
`endif
            take_left[k] = lvl_valid[2*k] && (!lvl_valid[2*k+1] || left_better[k]);
            red_valid[k] = lvl_valid[2*k] | lvl_valid[2*k+1];
            red_rank[k]  = take_left[k] ? lvl_rank[2*k] : lvl_rank[2*k+1];
            red_idx[k]   = take_left[k] ? lvl_idx[2*k]  : lvl_idx[2*k+1];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt = state;
        deq_valid = 1'b0;
        ins_ready = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = !full && !rst;
                if (do_snap) begin
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (lvl_cnt == LAST_LVL) begin
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                deq_valid = 1'b1;
                if (deq_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Occupancy, level counter and presented winner
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            count      <= '0;
            lvl_cnt    <= '0;
            deq_rank   <= '0;
            deq_meta   <= '0;
            deq_idx    <= '0;
        end else begin
            if (do_insert) begin
                slot_valid[free_idx] <= 1'b1;
                count                <= count + ONE_CNT;
            end
            if (do_snap) begin
                lvl_cnt <= '0;
            end
            if (state == SEARCH) begin
                lvl_cnt <= lvl_cnt + ONE_LVL;
            end
            if (search_last) begin
                deq_rank <= red_rank[0];
                deq_idx  <= red_idx[0];
                deq_meta <= slot_meta[red_idx[0]];
            end
            if (do_deq) begin
                slot_valid[deq_idx] <= 1'b0;
                count               <= count - ONE_CNT;
            end
        end
    end

    // Slot payload storage; contents are qualified by slot_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (do_insert) begin
            slot_rank[free_idx] <= ins_rank;
            slot_meta[free_idx] <= ins_meta;
        end
    end

    // Snapshot on dequeue start, then fold one tree level per SEARCH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_valid <= '0;
        end else if (do_snap) begin
            lvl_valid <= slot_valid;
        end else if (state == SEARCH) begin
            lvl_valid[HALF-1:0] <= red_valid;
        end
    end

    // Search rank/index registers, same load/fold schedule as lvl_valid
    always_ff @(posedge clk) begin
        if (do_snap) begin
            for (int i = 0; i < REG_WIDTH; i++) begin
                lvl_rank[i] <= slot_rank[i];
                lvl_idx[i]  <= IDX_WIDTH'(i);
            end
        end else if (state == SEARCH) begin
            for (int k = 0; k < HALF; k++) begin
                lvl_rank[k] <= red_rank[k];
                lvl_idx[k]  <= red_idx[k];
            end
        end
    end

endmodule

// File: tb/tb_pifo_max_sched.sv
// tb/tb_pifo_max_sched.sv - self-checking bench for pifo_max_sched with a slot-level reference model
module tb_pifo_max_sched;

    localparam int RW  = 4;
    localparam int IW  = 2;
    localparam int RKW = 16;
    localparam int MW  = 32;

    logic           clk;
    logic           rst;
    logic           ins_valid;
    logic           ins_ready;
    logic [RKW-1:0] ins_rank;
    logic [MW-1:0]  ins_meta;
    logic           deq_req;
    logic           deq_valid;
    logic           deq_ready;
    logic [RKW-1:0] deq_rank;
    logic [MW-1:0]  deq_meta;
    logic [IW-1:0]  deq_idx;
    logic [IW:0]    count;
    logic           empty;
    logic           full;

    int errors = 0;
    int checks = 0;

    bit       m_valid [RW];
    int       m_rank  [RW];
    logic [MW-1:0] m_meta [RW];

    pifo_max_sched #(
        .REG_WIDTH (RW),
        .IDX_WIDTH (IW),
        .RANK_WIDTH(RKW),
        .META_WIDTH(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .ins_rank (ins_rank),
        .ins_meta (ins_meta),
        .deq_req  (deq_req),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_rank (deq_rank),
        .deq_meta (deq_meta),
        .deq_idx  (deq_idx),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < RW; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < RW; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_insert(input int rank, input logic [MW-1:0] meta);
        for (int i = 0; i < RW; i++) begin
            if (!m_valid[i]) begin
                m_valid[i] = 1'b1;
                m_rank[i]  = rank;
                m_meta[i]  = meta;
                return;
            end
        end
    endfunction

    // Best entry by linear scan; ">=" / "<=" makes equal ranks prefer the later slot
    function automatic int m_pick();
        int w = -1;
        for (int i = 0; i < RW; i++) begin
            if (m_valid[i]) begin
`ifdef PIFO_SCHED_MIN_EN
                if (w < 0 || m_rank[i] <= m_rank[w]) w = i;
`else
                if (w < 0 || m_rank[i] >= m_rank[w]) w = i;
`endif
            end
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ins_valid = 1'b0;
        deq_req = 1'b0;
        deq_ready = 1'b0;
        ins_rank = '0;
        ins_meta = '0;
        tick();
        chk("ins_ready_in_rst", ins_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        m_clear();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_ins_ready", ins_ready, 1);
    endtask

    task automatic do_insert(input int rank, input logic [MW-1:0] meta);
        int n = 0;
        ins_valid = 1'b1;
        ins_rank = RKW'(rank);
        ins_meta = meta;
        while (!ins_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ins_wait_bound", (n < 20), 1);
        tick();
        ins_valid = 1'b0;
        m_insert(rank, meta);
        chk("ins_count", count, m_count());
    endtask

    task automatic do_dequeue(input int exp_lat);
        int n = 0;
        int w;
        w = m_pick();
        deq_req = 1'b1;
        while (!deq_valid && n < 20) begin
            tick();
            n++;
        end
        chk("deq_latency", n, exp_lat);
        chk("deq_rank", deq_rank, m_rank[w]);
        chk("deq_meta", deq_meta, m_meta[w]);
        chk("deq_idx", deq_idx, w);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        deq_req = 1'b0;
        m_valid[w] = 1'b0;
        chk("deq_valid_drop", deq_valid, 0);
        chk("deq_count", count, m_count());
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ins_valid = 1'b0;
        deq_req = 1'b0;
        deq_ready = 1'b0;
        ins_rank = '0;
        ins_meta = '0;
        m_clear();

        // basic ordering
        do_reset();
        do_insert(5, 32'hA);
        do_insert(9, 32'hB);
        do_insert(3, 32'hC);
        chk("s1_count", count, 3);
        do_dequeue(IW + 1);
        do_dequeue(IW + 1);
        do_dequeue(IW + 1);
        chk("s1_empty", empty, 1);

        // tie goes to higher index
        do_reset();
        do_insert(7, 32'hA);
        do_insert(1, 32'hB);
        do_insert(7, 32'hC);
        do_dequeue(IW + 1);

        // full and held insert
        do_reset();
        do_insert(2, 32'h1);
        do_insert(6, 32'h2);
        do_insert(6, 32'h3);
        do_insert(1, 32'h4);
        chk("full_flag", full, 1);
        chk("full_ins_ready", ins_ready, 0);
        ins_valid = 1'b1;
        ins_rank = 16'd8;
        ins_meta = 32'hE;
        tick();
        tick();
        tick();
        chk("held_count", count, 4);
        do_dequeue(IW + 1);
        tick();
        ins_valid = 1'b0;
        m_insert(8, 32'hE);
        chk("refill_count", count, 4);
        do_dequeue(IW + 1);

        // insert priority over deq_req in the same cycle
        do_reset();
        do_insert(4, 32'hA);
        do_insert(6, 32'hB);
        ins_valid = 1'b1;
        ins_rank = 16'd20;
        ins_meta = 32'hD;
        deq_req = 1'b1;
        tick();
        ins_valid = 1'b0;
        m_insert(20, 32'hD);
        chk("prio_count", count, 3);
        chk("prio_no_valid", deq_valid, 0);
        do_dequeue(IW + 1);

        // deq_req on empty is ignored
        do_reset();
        deq_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty_deq_valid", deq_valid, 0);
        end
        deq_req = 1'b0;

        // reset while presenting
        do_insert(3, 32'h31);
        do_insert(5, 32'h51);
        deq_req = 1'b1;
        n = 0;
        while (!deq_valid && n < 20) begin
            tick();
            n++;
        end
        chk("pres_valid", deq_valid, 1);
        rst = 1'b1;
        tick();
        deq_req = 1'b0;
        chk("pres_rst_valid", deq_valid, 0);
        chk("pres_rst_count", count, 0);
        chk("pres_rst_ins_ready", ins_ready, 0);
        rst = 1'b0;
        #1;
        m_clear();
        chk("post_rst_ins_ready", ins_ready, 1);

        // randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            if (m_count() == 0 || (m_count() < RW && $urandom_range(0, 1) == 0)) begin
                do_insert(int'($urandom_range(0, 15)), $urandom);
            end else begin
                do_dequeue(IW + 1);
            end
        end
        while (m_count() > 0) do_dequeue(IW + 1);
        chk("final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
